// File: rtl/ram_pkg.sv
// Shared types and constants for the data-RAM arbiter and its alignment checker.
package ram_pkg;

    localparam logic [1:0] MEM_BYTE    = 2'd0;
    localparam logic [1:0] MEM_HALF    = 2'd1;
    localparam logic [1:0] MEM_WORD    = 2'd2;
    localparam logic [1:0] MEM_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESP_IF,
        ST_RESP_D
    } state_e;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_e;

endpackage

// File: rtl/ram_align_chk.sv
// Flags data accesses that are misaligned for their size or use the reserved size code.
module ram_align_chk
    import ram_pkg::*;
(
    input  logic [1:0] mem_ctrl,
    input  logic [1:0] addr_lo,
    output logic       err
);

    always_comb begin
        unique case (mem_ctrl)
            MEM_BYTE: err = 1'b0;
            MEM_HALF: err = addr_lo[0];
            MEM_WORD: err = (addr_lo != 2'b00);
            default:  err = 1'b1;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port data RAM between instruction fetch and load/store, one grant per
// cycle, with a single-cycle response pulse for every grant.
module ram_arbiter
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned FAIR   = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_mem_ctrl,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,

    output logic              ram_we,
    output logic [1:0]        ram_mem_ctrl,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);

    state_e            state_q;
    owner_e            last_owner_q;
    logic              d_err_q;
    logic              d_store_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic [1:0]        ram_mem_ctrl_q;
    logic [ADDR_W-1:0] ram_address_q;
    logic [DATA_W-1:0] ram_data_in_q;

    logic              d_align_err;
    logic              d_wins;
    logic [ADDR_W-1:0] fetch_addr;

    ram_align_chk u_align_chk (
        .mem_ctrl (d_mem_ctrl),
        .addr_lo  (d_addr[1:0]),
        .err      (d_align_err)
    );

    // Fetches are always whole words; the low address bits are dropped.
    assign fetch_addr = if_addr & ~ADDR_W'(3);

    always_comb begin
        d_wins = d_req && (!if_req || (FAIR == 0) || (last_owner_q == OWN_IF));
        d_gnt  = rst_n && d_wins;
        if_gnt = rst_n && if_req && !d_wins;
    end

    // Illegal data accesses are consumed but must never reach the RAM as a write.
    always_comb begin
        ram_we       = d_gnt && d_we && !d_align_err;
        ram_mem_ctrl = ram_mem_ctrl_q;
        ram_address  = ram_address_q;
        ram_data_in  = ram_data_in_q;
        if (if_gnt) begin
            ram_mem_ctrl = MEM_WORD;
            ram_address  = fetch_addr;
        end else if (d_gnt) begin
            ram_mem_ctrl = d_mem_ctrl;
            ram_address  = d_addr;
            ram_data_in  = d_wdata;
        end
    end

    // Responses are gated by reset so a pending one is dropped the moment reset is seen.
    always_comb begin
        if_rvalid = rst_n && (state_q == ST_RESP_IF);
        d_rvalid  = rst_n && (state_q == ST_RESP_D);
        d_err     = d_rvalid && d_err_q;
        if (!rst_n) begin
            if_rdata = '0;
        end else if (if_rvalid) begin
            if_rdata = ram_data_out;
        end else begin
            if_rdata = if_rdata_q;
        end
        if (!rst_n) begin
            d_rdata = '0;
        end else if (d_rvalid) begin
            d_rdata = (d_err_q || d_store_q) ? '0 : ram_data_out;
        end else begin
            d_rdata = d_rdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            last_owner_q   <= OWN_IF;
            d_err_q        <= 1'b0;
            d_store_q      <= 1'b0;
            if_rdata_q     <= '0;
            d_rdata_q      <= '0;
            ram_mem_ctrl_q <= '0;
            ram_address_q  <= '0;
            ram_data_in_q  <= '0;
        end else begin
            if_rdata_q     <= if_rdata;
            d_rdata_q      <= d_rdata;
            ram_mem_ctrl_q <= ram_mem_ctrl;
            ram_address_q  <= ram_address;
            ram_data_in_q  <= ram_data_in;
            if (if_gnt) begin
                state_q      <= ST_RESP_IF;
                last_owner_q <= OWN_IF;
            end else if (d_gnt) begin
                state_q      <= ST_RESP_D;
                last_owner_q <= OWN_D;
                d_err_q      <= d_align_err;
                d_store_q    <= d_we;
            end else begin
                state_q <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus a randomized run against a
// behavioural model of arbitration, alignment and the RAM contents.
module tb_ram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [1:0]  d_mem_ctrl;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        ram_we;
    logic [1:0]  ram_mem_ctrl;
    logic [31:0] ram_address, ram_data_in, ram_data_out;

    logic        fx_if_gnt, fx_if_rvalid, fx_d_gnt, fx_d_rvalid, fx_d_err, fx_ram_we;
    logic [31:0] fx_if_rdata, fx_d_rdata, fx_ram_address, fx_ram_data_in, fx_rdo;
    logic [1:0]  fx_ram_mem_ctrl;

    logic [31:0] env_mem [16];
    logic [31:0] ref_mem [16];
    int          n_cmp;
    int          n_fail;

    assign fx_rdo = '0;

    ram_arbiter #(.ADDR_W(32), .DATA_W(32), .FAIR(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_mem_ctrl(d_mem_ctrl), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .d_err(d_err),
        .ram_we(ram_we), .ram_mem_ctrl(ram_mem_ctrl), .ram_address(ram_address),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    ram_arbiter #(.ADDR_W(32), .DATA_W(32), .FAIR(0)) dut_fixed (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(fx_if_gnt), .if_rvalid(fx_if_rvalid),
        .if_rdata(fx_if_rdata),
        .d_req(d_req), .d_we(d_we), .d_mem_ctrl(d_mem_ctrl), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(fx_d_gnt), .d_rvalid(fx_d_rvalid), .d_rdata(fx_d_rdata),
        .d_err(fx_d_err),
        .ram_we(fx_ram_we), .ram_mem_ctrl(fx_ram_mem_ctrl), .ram_address(fx_ram_address),
        .ram_data_in(fx_ram_data_in), .ram_data_out(fx_rdo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] ctrl,
                                          input logic [1:0] lo, input logic [31:0] wd);
        logic [31:0] mask;
        int          sh;
        sh = int'(lo) * 8;
        case (ctrl)
            2'd0:    mask = 32'h0000_00FF;
            2'd1:    mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        return (old & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    // Simple RAM: one-cycle read latency, writes land at the clock edge.
    always @(posedge clk) begin
        if (ram_we) begin
            env_mem[ram_address[5:2]] <= merge(env_mem[ram_address[5:2]], ram_mem_ctrl,
                                               ram_address[1:0], ram_data_in);
        end
        ram_data_out <= env_mem[ram_address[5:2]];
    end

    task automatic drive_point();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle();
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_mem_ctrl = 2'd2; d_addr = '0; d_wdata = '0;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        rst_n = 1'b0;
        idle();
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
        drive_point();
        drive_point();
        sample();
        got = {if_gnt, d_gnt, ram_we, if_rvalid, d_rvalid, d_err, |if_rdata, |d_rdata};
        n_cmp++;
        if (got !== 8'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b want 00000000", got);
        end
        drive_point();
    endtask

    task automatic test_store_load();
        rst_n = 1'b1;
        idle();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0; d_wdata = 32'h1234_5678;
        sample();
        n_cmp++;
        if ({d_gnt, if_gnt, ram_we} !== 3'b101) begin
            n_fail++; $display("FAIL store_grant: got %b want 101", {d_gnt, if_gnt, ram_we});
        end
        n_cmp++;
        if ({ram_address, ram_mem_ctrl, ram_data_in} !== {32'h0, 2'd2, 32'h1234_5678}) begin
            n_fail++; $display("FAIL store_ram_drive: got %h %h %h want 0 2 12345678",
                               ram_address, ram_mem_ctrl, ram_data_in);
        end
        drive_point();
        d_we = 1'b0;
        sample();
        n_cmp++;
        if ({d_gnt, ram_we, d_rvalid, d_err} !== 4'b1010) begin
            n_fail++; $display("FAIL load_grant_store_resp: got %b want 1010",
                               {d_gnt, ram_we, d_rvalid, d_err});
        end
        n_cmp++;
        if (d_rdata !== 32'h0) begin
            n_fail++; $display("FAIL store_rdata: got %h want 0", d_rdata);
        end
        drive_point();
        idle();
        sample();
        n_cmp++;
        if ({d_gnt, d_rvalid, d_err} !== 3'b010) begin
            n_fail++; $display("FAIL load_resp: got %b want 010", {d_gnt, d_rvalid, d_err});
        end
        n_cmp++;
        if (d_rdata !== 32'h1234_5678) begin
            n_fail++; $display("FAIL load_rdata: got %h want 12345678", d_rdata);
        end
        drive_point();
        sample();
        n_cmp++;
        if ({d_rvalid, d_rdata} !== {1'b0, 32'h1234_5678}) begin
            n_fail++; $display("FAIL rdata_hold: got %b %h want 0 12345678", d_rvalid, d_rdata);
        end
        drive_point();
    endtask

    task automatic test_reset_discard();
        logic [7:0] got;
        d_req = 1'b1; d_we = 1'b0; d_mem_ctrl = 2'd2; d_addr = 32'h0;
        sample();
        n_cmp++;
        if (d_gnt !== 1'b1) begin
            n_fail++; $display("FAIL discard_load_grant: got %b want 1", d_gnt);
        end
        drive_point();
        idle();
        rst_n = 1'b0;
        sample();
        got = {d_rvalid, if_rvalid, d_err, |d_rdata, |if_rdata, d_gnt, if_gnt, ram_we};
        n_cmp++;
        if (got !== 8'b0) begin
            n_fail++; $display("FAIL discard_in_reset: got %b want 00000000", got);
        end
        drive_point();
        rst_n = 1'b1;
        sample();
        n_cmp++;
        if ({d_rvalid, if_rvalid, d_rdata} !== 34'b0) begin
            n_fail++; $display("FAIL discard_after_reset: got %b %b %h want 0 0 0",
                               d_rvalid, if_rvalid, d_rdata);
        end
        drive_point();
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_addr = 32'h20;
        sample();
        n_cmp++;
        if ({d_gnt, if_gnt} !== 2'b10) begin
            n_fail++; $display("FAIL first_conflict: got %b want 10", {d_gnt, if_gnt});
        end
        drive_point();
        idle();
    endtask

    task automatic test_fair();
        logic exp_d;
        rst_n = 1'b0;
        idle();
        drive_point();
        rst_n = 1'b1;
        if_req = 1'b1; if_addr = 32'h8;
        d_req = 1'b1; d_we = 1'b0; d_mem_ctrl = 2'd2; d_addr = 32'h0;
        for (int i = 0; i < 4; i++) begin
            exp_d = (i % 2 == 0);
            sample();
            n_cmp++;
            if ({d_gnt, if_gnt} !== {exp_d, !exp_d}) begin
                n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", i, {d_gnt, if_gnt},
                                   {exp_d, !exp_d});
            end
            n_cmp++;
            if ({fx_d_gnt, fx_if_gnt} !== 2'b10) begin
                n_fail++; $display("FAIL fixed_grant[%0d]: got %b want 10", i,
                                   {fx_d_gnt, fx_if_gnt});
            end
            if (i > 0) begin
                n_cmp++;
                if ({if_rvalid, d_rvalid} !== {exp_d, !exp_d}) begin
                    n_fail++; $display("FAIL rr_rvalid[%0d]: got %b want %b", i,
                                       {if_rvalid, d_rvalid}, {exp_d, !exp_d});
                end
            end
            drive_point();
        end
        idle();
        sample();
        n_cmp++;
        if ({if_rvalid, d_rvalid} !== 2'b10) begin
            n_fail++; $display("FAIL rr_last_rvalid: got %b want 10", {if_rvalid, d_rvalid});
        end
        drive_point();
    endtask

    task automatic test_misaligned();
        logic [1:0]  ctrl_t [4];
        logic [31:0] addr_t [4];
        logic        err_t  [4];
        ctrl_t = '{2'd1, 2'd2, 2'd3, 2'd0};
        addr_t = '{32'd13, 32'd14, 32'd0, 32'd13};
        err_t  = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            d_req = 1'b1; d_we = 1'b1; d_mem_ctrl = ctrl_t[i]; d_addr = addr_t[i];
            d_wdata = $urandom;
            sample();
            n_cmp++;
            if ({d_gnt, ram_we} !== {1'b1, !err_t[i]}) begin
                n_fail++; $display("FAIL align_grant[%0d]: got %b want %b", i, {d_gnt, ram_we},
                                   {1'b1, !err_t[i]});
            end
            if (i > 0) begin
                n_cmp++;
                if ({d_rvalid, d_err, d_rdata} !== {1'b1, err_t[i-1], 32'h0}) begin
                    n_fail++; $display("FAIL align_resp[%0d]: got %b %b %h want 1 %b 0", i - 1,
                                       d_rvalid, d_err, d_rdata, err_t[i-1]);
                end
            end
            drive_point();
        end
        idle();
        sample();
        n_cmp++;
        if ({d_rvalid, d_err, d_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            n_fail++; $display("FAIL align_resp[3]: got %b %b %h want 1 0 0",
                               d_rvalid, d_err, d_rdata);
        end
        drive_point();
    endtask

    task automatic test_fetch();
        d_req = 1'b1; d_we = 1'b1; d_mem_ctrl = 2'd2; d_addr = 32'h4; d_wdata = 32'hCAFE_F00D;
        sample();
        n_cmp++;
        if (d_gnt !== 1'b1) begin
            n_fail++; $display("FAIL fetch_preload_grant: got %b want 1", d_gnt);
        end
        drive_point();
        idle();
        if_req = 1'b1; if_addr = 32'h0000_0007;
        sample();
        n_cmp++;
        if ({if_gnt, d_gnt, ram_we, ram_mem_ctrl, ram_address} !==
            {3'b100, 2'd2, 32'h0000_0004}) begin
            n_fail++; $display("FAIL fetch_drive: got %b%b%b %h %h want 100 2 00000004",
                               if_gnt, d_gnt, ram_we, ram_mem_ctrl, ram_address);
        end
        drive_point();
        idle();
        sample();
        n_cmp++;
        if ({if_rvalid, d_rvalid, if_rdata} !== {2'b10, 32'hCAFE_F00D}) begin
            n_fail++; $display("FAIL fetch_resp: got %b %b %h want 1 0 cafef00d",
                               if_rvalid, d_rvalid, if_rdata);
        end
        drive_point();
    endtask

    task automatic test_random();
        logic        m_last_if, g_if, g_d, illegal, exp_we;
        logic        p_if_v, p_d_v, p_d_err;
        logic [31:0] p_if_data, p_d_data, last_if, last_d;
        int          sz;
        for (int w = 0; w < 16; w++) begin
            d_req = 1'b1; d_we = 1'b1; d_mem_ctrl = 2'd2; d_addr = 32'(w * 4);
            d_wdata = $urandom;
            ref_mem[w] = d_wdata;
            drive_point();
        end
        idle();
        drive_point();
        rst_n = 1'b0;
        drive_point();
        rst_n = 1'b1;
        m_last_if = 1'b1;
        p_if_v = 1'b0; p_d_v = 1'b0; p_d_err = 1'b0; p_if_data = '0; p_d_data = '0;
        last_if = '0; last_d = '0;
        g_if = 1'b0; g_d = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!(if_req && !g_if && $urandom_range(7) != 0)) begin
                if_req = 1'($urandom_range(1)); if_addr = 32'($urandom_range(63));
            end
            if (!(d_req && !g_d && $urandom_range(7) != 0)) begin
                d_req = 1'($urandom_range(1)); d_we = 1'($urandom_range(1));
                d_mem_ctrl = ($urandom_range(5) == 0) ? 2'd3 : 2'($urandom_range(2));
                d_addr = 32'($urandom_range(63)); d_wdata = $urandom;
            end
            sample();
            n_cmp++;
            if ({if_rvalid, if_rdata} !== {p_if_v, p_if_v ? p_if_data : last_if}) begin
                n_fail++; $display("FAIL rnd_if_resp[%0d]: got %b %h want %b %h", c, if_rvalid,
                                   if_rdata, p_if_v, p_if_v ? p_if_data : last_if);
            end
            n_cmp++;
            if ({d_rvalid, d_err, d_rdata} !==
                {p_d_v, p_d_v && p_d_err, p_d_v ? p_d_data : last_d}) begin
                n_fail++; $display("FAIL rnd_d_resp[%0d]: got %b %b %h want %b %b %h", c,
                                   d_rvalid, d_err, d_rdata, p_d_v, p_d_v && p_d_err,
                                   p_d_v ? p_d_data : last_d);
            end
            if (p_if_v) last_if = p_if_data;
            if (p_d_v) last_d = p_d_data;
            g_d  = d_req && (!if_req || m_last_if);
            g_if = if_req && !g_d;
            sz = 1 << d_mem_ctrl;
            illegal = (d_mem_ctrl == 2'd3) || ((d_addr % sz) != 0);
            exp_we = g_d && d_we && !illegal;
            n_cmp++;
            if ({if_gnt, d_gnt, ram_we} !== {g_if, g_d, exp_we}) begin
                n_fail++; $display("FAIL rnd_grant[%0d]: got %b want %b", c,
                                   {if_gnt, d_gnt, ram_we}, {g_if, g_d, exp_we});
            end
            if (g_if) begin
                n_cmp++;
                if ({ram_address, ram_mem_ctrl} !== {if_addr - (if_addr % 4), 2'd2}) begin
                    n_fail++; $display("FAIL rnd_if_drive[%0d]: got %h %h want %h 2", c,
                                       ram_address, ram_mem_ctrl, if_addr - (if_addr % 4));
                end
            end
            if (exp_we) begin
                n_cmp++;
                if ({ram_address, ram_mem_ctrl, ram_data_in} !== {d_addr, d_mem_ctrl, d_wdata})
                begin
                    n_fail++; $display("FAIL rnd_d_drive[%0d]: got %h %h %h want %h %h %h", c,
                                       ram_address, ram_mem_ctrl, ram_data_in, d_addr,
                                       d_mem_ctrl, d_wdata);
                end
            end
            p_if_v = g_if;
            p_if_data = ref_mem[if_addr[5:2]];
            p_d_v = g_d;
            p_d_err = illegal;
            p_d_data = (g_d && !d_we && !illegal) ? ref_mem[d_addr[5:2]] : 32'h0;
            if (exp_we) begin
                ref_mem[d_addr[5:2]] = merge(ref_mem[d_addr[5:2]], d_mem_ctrl, d_addr[1:0],
                                             d_wdata);
            end
            if (g_if) m_last_if = 1'b1;
            if (g_d) m_last_if = 1'b0;
            drive_point();
        end
        idle();
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_store_load();
        test_reset_discard();
        test_fair();
        test_misaligned();
        test_fetch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
